// File: rtl/muldiv_pkg.sv
// RV32M multiply/divide encodings, FSM states and shared helpers.
package muldiv_pkg;

    localparam int MD_XLEN = 32;
    localparam int ITER_W  = $clog2(MD_XLEN) + 1;

    localparam logic [MD_XLEN-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Two's-complement negate when neg is set; double width so it serves both product and operands.
    function automatic logic [2*MD_XLEN-1:0] cond_neg(input logic [2*MD_XLEN-1:0] v, input logic neg);
        return neg ? (~v + {{(2*MD_XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/result handshake bundle between execute stage and muldiv_unit.
interface muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic [2:0]            Funct3;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] MDResult;

    modport master (
        output in_valid, SrcA, SrcB, Funct3, out_ready,
        input  in_ready, out_valid, MDResult
    );

    modport slave (
        input  in_valid, SrcA, SrcB, Funct3, out_ready,
        output in_ready, out_valid, MDResult
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, radix-2 shift-add / restoring divide.
// Latency: result valid 33 cycles after accept (1 cycle for divide-by-zero / signed overflow).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_XLEN
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave md
);
    localparam int DW = DATA_WIDTH;

    md_state_e         state;
    md_funct3_e        op;
    logic [DW-1:0]     a_mag;
    logic [DW-1:0]     b_mag;
    logic [DW-1:0]     hi;
    logic [DW-1:0]     lo;
    logic [DW-1:0]     result;
    logic              neg;
    logic [ITER_W-1:0] cnt;

    md_funct3_e    op_in;
    logic          a_neg_in, b_neg_in, neg_in;
    logic          div_zero, div_ovf;
    logic [2*DW-1:0] a_full, b_full;
    logic [DW-1:0] a_mag_in, b_mag_in, special_res;

    always_comb begin
        op_in    = md_funct3_e'(md.Funct3);
        a_neg_in = md.SrcA[DW-1] & (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        b_neg_in = md.SrcB[DW-1] & (op_in inside {MD_MULH, MD_DIV, MD_REM});
        a_full   = cond_neg({{DW{1'b0}}, md.SrcA}, a_neg_in);
        b_full   = cond_neg({{DW{1'b0}}, md.SrcB}, b_neg_in);
        a_mag_in = a_full[DW-1:0];
        b_mag_in = b_full[DW-1:0];
        // Remainder takes the dividend's sign; everything else the XOR of operand signs.
        neg_in   = (op_in == MD_REM) ? a_neg_in : (a_neg_in ^ b_neg_in);
        div_zero = md.Funct3[2] & (md.SrcB == '0);
        div_ovf  = (op_in == MD_DIV || op_in == MD_REM) &&
                   (md.SrcA == {1'b1, {(DW-1){1'b0}}}) && (md.SrcB == '1);
        if (div_zero) begin
            special_res = md.Funct3[1] ? md.SrcA : DIV_ZERO_Q;
        end else begin
            special_res = md.Funct3[1] ? '0 : md.SrcA;
        end
    end

    logic [DW:0]     mul_sum, div_shift, div_sub;
    logic            div_fit;
    logic [DW-1:0]   hi_nxt, lo_nxt, res_word;
    logic [2*DW-1:0] res_full;

    // Multiply keeps the multiplier in lo and shifts the product in from the top;
    // divide keeps the dividend in lo and shifts quotient bits in from the bottom.
    always_comb begin
        mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? a_mag : {DW{1'b0}})};
        div_shift = {hi, lo[DW-1]};
        div_fit   = div_shift >= {1'b0, b_mag};
        div_sub   = div_shift - {1'b0, b_mag};
        if (op[2]) begin
            hi_nxt = div_fit ? div_sub[DW-1:0] : div_shift[DW-1:0];
            lo_nxt = {lo[DW-2:0], div_fit};
        end else begin
            hi_nxt = mul_sum[DW:1];
            lo_nxt = {mul_sum[0], lo[DW-1:1]};
        end
        res_full = cond_neg(op[2] ? {{DW{1'b0}}, (op[1] ? hi_nxt : lo_nxt)} : {hi_nxt, lo_nxt}, neg);
        res_word = (op == MD_MUL || op[2]) ? res_full[DW-1:0] : res_full[2*DW-1:DW];
    end

    logic unused;
    assign unused = ^{div_sub[DW], a_full[2*DW-1:DW], b_full[2*DW-1:DW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= MD_MUL;
            a_mag  <= '0;
            b_mag  <= '0;
            hi     <= '0;
            lo     <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md.in_valid) begin
                        op    <= op_in;
                        a_mag <= a_mag_in;
                        b_mag <= b_mag_in;
                        neg   <= neg_in;
                        cnt   <= '0;
                        hi    <= '0;
                        lo    <= md.Funct3[2] ? a_mag_in : b_mag_in;
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == ITER_W'(DW-1)) begin
                        result <= res_word;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (md.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.in_ready  = (state == IDLE);
    assign md.out_valid = (state == DONE);
    assign md.MDResult  = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: directed RV32M cases, special divides, backpressure, reset abort, random ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.DATA_WIDTH(DW)) md ();

    muldiv_unit #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       nm;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input int lat, input string nm);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.res = res; v.lat = lat; v.nm = nm;
        return v;
    endfunction

    // Reference behaviour using the simulator's own signed/unsigned arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0]        p;
        logic signed [31:0] as, bs, q;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        as  = a;
        bs  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                q = as / bs; return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = as % bs; return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive one op for a single accept edge and record its expected result.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        @(negedge clk);
        md.Funct3   = f3;
        md.SrcA     = a;
        md.SrcB     = b;
        md.in_valid = 1'b1;
        exp_q.push_back(res);
        @(posedge clk);
        #1;
        md.in_valid = 1'b0;
    endtask

    // Count cycles after the accept edge until out_valid, noting any in_ready while busy.
    task automatic wait_result(output int n, output bit busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (md.in_ready) busy_ok = 1'b0;
            if (md.out_valid) break;
        end
    endtask

    task automatic retire();
        md.out_ready = 1'b1;
        @(posedge clk);
        #1;
        md.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (md.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", md.in_ready); end
        checks++; if (md.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", md.out_valid); end
        checks++; if (md.MDResult !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=00000000", md.MDResult); end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int n; bit busy_ok; logic [31:0] want;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        wait_result(n, busy_ok);
        want = exp_q.pop_front();
        checks++; if (n !== 33) begin failures++; $display("FAIL mul_latency got=%0d want=33", n); end
        checks++; if (md.MDResult !== want) begin failures++; $display("FAIL mul_result got=%h want=%h", md.MDResult, want); end
        checks++; if (!busy_ok) begin failures++; $display("FAIL mul_in_ready_busy got=1 want=0"); end
        retire();
    endtask

    task automatic test_table(input vec_t tbl[$]);
        int n; bit busy_ok; logic [31:0] want;
        foreach (tbl[i]) begin
            issue(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].res);
            wait_result(n, busy_ok);
            want = exp_q.pop_front();
            checks++; if (n !== tbl[i].lat) begin failures++; $display("FAIL %s_latency got=%0d want=%0d", tbl[i].nm, n, tbl[i].lat); end
            checks++; if (md.MDResult !== want) begin failures++; $display("FAIL %s_result got=%h want=%h", tbl[i].nm, md.MDResult, want); end
            checks++; if (!busy_ok) begin failures++; $display("FAIL %s_in_ready_busy got=1 want=0", tbl[i].nm); end
            retire();
        end
    endtask

    task automatic test_mulh_div();
        vec_t t[$];
        t.push_back(mk(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh"));
        t.push_back(mk(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu"));
        t.push_back(mk(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu"));
        t.push_back(mk(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div"));
        t.push_back(mk(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem"));
        t.push_back(mk(3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33, "divu"));
        t.push_back(mk(3'b111, 32'd100,       32'd7,         32'd2,         33, "remu"));
        test_table(t);
    endtask

    task automatic test_special();
        vec_t t[$];
        t.push_back(mk(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "div_by_zero"));
        t.push_back(mk(3'b111, 32'd5,         32'd0,         32'd5,         1, "remu_by_zero"));
        t.push_back(mk(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_overflow"));
        t.push_back(mk(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "rem_overflow"));
        test_table(t);
    endtask

    task automatic test_backpressure();
        int n; bit busy_ok; logic [31:0] want;
        issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0));
        wait_result(n, busy_ok);
        want = exp_q.pop_front();
        checks++; if (n !== 33) begin failures++; $display("FAIL bp_latency got=%0d want=33", n); end
        for (int i = 0; i < 10; i++) begin
            // A divide-by-zero here would finish in one cycle if it were wrongly accepted.
            md.in_valid = (i % 2 == 0);
            md.Funct3   = 3'b101;
            md.SrcA     = 32'hDEAD_0000 + i;
            md.SrcB     = 32'h0;
            @(negedge clk);
            checks++; if (md.out_valid !== 1'b1 || md.MDResult !== want) begin
                failures++; $display("FAIL bp_hold_%0d got=%b/%h want=1/%h", i, md.out_valid, md.MDResult, want);
            end
        end
        md.in_valid = 1'b0;
        retire();
        @(negedge clk);
        checks++; if (md.in_ready !== 1'b1 || md.out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release got=in_ready %b out_valid %b want=1 0", md.in_ready, md.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit busy_ok; logic [31:0] want;
        issue(3'b000, 32'h0001_0001, 32'h0000_FFFF, model(3'b000, 32'h0001_0001, 32'h0000_FFFF));
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (md.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b want=0", md.out_valid); end
        checks++; if (md.MDResult !== 32'h0) begin failures++; $display("FAIL rstmid_result got=%h want=00000000", md.MDResult); end
        checks++; if (md.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b want=1", md.in_ready); end
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b000, 32'd3, 32'd4, 32'd12);
        wait_result(n, busy_ok);
        want = exp_q.pop_front();
        checks++; if (n !== 33) begin failures++; $display("FAIL rstmid_mul_latency got=%0d want=33", n); end
        checks++; if (md.MDResult !== want) begin failures++; $display("FAIL rstmid_mul_result got=%h want=%h", md.MDResult, want); end
        retire();
    endtask

    task automatic test_random();
        vec_t t[$];
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = {1'b1, 31'($urandom_range(0, 3))};
            t.push_back(mk(f3, a, b, model(f3, a, b), model_lat(f3, a, b), $sformatf("rand%0d_f%0d", i, f3)));
        end
        test_table(t);
    endtask

    initial begin
        md.in_valid  = 1'b0;
        md.out_ready = 1'b0;
        md.SrcA      = '0;
        md.SrcB      = '0;
        md.Funct3    = '0;
        test_reset();
        test_mul();
        test_mulh_div();
        test_special();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
